// File: rtl/mini_core_pkg.sv
// mini_core_pkg: shared constants for the mini_core pipeline.
//   INST_W           - instruction / datapath width
//   NOP_INST_DEFAULT - addi x0,x0,0, shown when no valid fetch data exists
//   RESET_PC_DEFAULT - default PC loaded on reset
//   PC_STEP          - sequential fetch increment
package mini_core_pkg;

    localparam int unsigned INST_W = 32;

    localparam logic [INST_W-1:0] NOP_INST_DEFAULT = 32'h0000_0013;
    localparam logic [INST_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INST_W-1:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/mini_core_if_if.sv
// mini_core_if_if: signal bundle between the fetch stage and the rest of the core / IMem.
//   master - fetch stage: drives PC, IMem read request and the Q101H instruction/PC
//   slave  - surroundings: drive the ready chain, redirect and IMem read data
interface mini_core_if_if;
    import mini_core_pkg::*;

    logic              ReadyQ100H;
    logic              ReadyQ101H;
    logic              ReadyQ102H;
    logic              SelNextPcAluOutQ102H;
    logic [INST_W-1:0] AluOutQ102H;
    logic [INST_W-1:0] PcQ100H;
    logic              IMemRdEnQ100H;
    logic [INST_W-1:0] IMemRdAddrQ100H;
    logic [INST_W-1:0] IMemRdDataQ101H;
    logic [INST_W-1:0] PcQ101H;
    logic [INST_W-1:0] PreInstructionQ101H;

    modport master (
        input  ReadyQ100H, ReadyQ101H, ReadyQ102H, SelNextPcAluOutQ102H, AluOutQ102H,
        input  IMemRdDataQ101H,
        output PcQ100H, IMemRdEnQ100H, IMemRdAddrQ100H, PcQ101H, PreInstructionQ101H
    );

    modport slave (
        output ReadyQ100H, ReadyQ101H, ReadyQ102H, SelNextPcAluOutQ102H, AluOutQ102H,
        output IMemRdDataQ101H,
        input  PcQ100H, IMemRdEnQ100H, IMemRdAddrQ100H, PcQ101H, PreInstructionQ101H
    );

endinterface

// File: rtl/mini_core_if_hold.sv
// mini_core_if_hold: replay register and output mux for a synchronous-read path.
//   i_clk, i_rst - clock, synchronous active-high reset
//   i_ready      - consuming stage may advance; when low the current value is replayed
//   i_valid      - i_rd_data holds a real read result this cycle
//   i_rd_data    - read data from a synchronous memory
//   o_data       - value presented to the consumer
module mini_core_if_hold
    import mini_core_pkg::*;
#(
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ready,
    input  logic              i_valid,
    input  logic [INST_W-1:0] i_rd_data,
    output logic [INST_W-1:0] o_data
);

    logic              r_hold_sel;
    logic [INST_W-1:0] r_inst_hold;
    logic [INST_W-1:0] w_data;

    // Memory data is not trusted across a stall: the value shown in the first stall
    // cycle is captured and replayed until the cycle after ready returns.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold_sel  <= 1'b0;
            r_inst_hold <= NOP_INST;
        end else begin
            r_hold_sel  <= !i_ready;
            r_inst_hold <= w_data;
        end
    end

    always_comb begin
        w_data = NOP_INST;
        if (r_hold_sel) begin
            w_data = r_inst_hold;
        end else if (i_valid) begin
            w_data = i_rd_data;
        end
    end

    assign o_data = w_data;

endmodule

// File: rtl/mini_core_if.sv
// mini_core_if: instruction-fetch stage (Q100H) of the mini_core pipeline.
//   Clock, Rst - core clock, synchronous active-high reset
//   bus        - master side of mini_core_if_if: ready chain, Q102H redirect, IMem read
//                request/data, and the PC/instruction pair presented to decode in Q101H
module mini_core_if
    import mini_core_pkg::*;
#(
    parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic            Clock,
    input  logic            Rst,
    mini_core_if_if.master  bus
);

    logic [INST_W-1:0] r_pc_q100h;
    logic [INST_W-1:0] r_pc_q101h;
    logic              r_fetch_valid_q101h;
    logic              w_redirect_q102h;
    logic [INST_W-1:0] w_target_q102h;
    logic [INST_W-1:0] w_pc_next;

    // A redirect is only honoured when Q102H advances; a frozen branch re-asserts later.
    assign w_redirect_q102h = bus.SelNextPcAluOutQ102H && bus.ReadyQ102H;
    assign w_target_q102h   = bus.AluOutQ102H & 32'hFFFF_FFFE;

    // Redirect beats the ready gate, even in the illegal redirect + load-hazard case.
    always_comb begin
        w_pc_next = r_pc_q100h;
        if (w_redirect_q102h) begin
            w_pc_next = w_target_q102h;
        end else if (bus.ReadyQ100H) begin
            w_pc_next = r_pc_q100h + PC_STEP;
        end
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            r_pc_q100h          <= RESET_PC;
            r_pc_q101h          <= RESET_PC;
            r_fetch_valid_q101h <= 1'b0;
        end else begin
            r_pc_q100h          <= w_pc_next;
            // A read is issued every non-reset cycle, so data is valid the cycle after.
            r_fetch_valid_q101h <= 1'b1;
            if (bus.ReadyQ101H) begin
                r_pc_q101h <= r_pc_q100h;
            end
        end
    end

    // The address is re-issued during stalls; the hold path covers the replay.
    assign bus.PcQ100H         = r_pc_q100h;
    assign bus.IMemRdEnQ100H   = !Rst;
    assign bus.IMemRdAddrQ100H = r_pc_q100h;
    assign bus.PcQ101H         = r_pc_q101h;

    mini_core_if_hold #(
        .NOP_INST (NOP_INST)
    ) u_hold (
        .i_clk     (Clock),
        .i_rst     (Rst),
        .i_ready   (bus.ReadyQ101H),
        .i_valid   (r_fetch_valid_q101h),
        .i_rd_data (bus.IMemRdDataQ101H),
        .o_data    (bus.PreInstructionQ101H)
    );

endmodule
